// File: rtl/arima_pkg.sv
// rtl/arima_pkg.sv - FSM states, Q-format constant and N-bit reduction helper for arima_serial_core
// ARIMA_SAT_EN selects saturating reduction; otherwise reductions wrap.
package arima_pkg;

    localparam int RW = 128;
    localparam int Q_DEFAULT = 15;
    localparam logic [31:0] ONE_Q = 32'd1 << Q_DEFAULT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_MAC,
        S_SCALE,
        S_INTEG,
        S_OUT
    } state_t;

    // Result is returned at RW bits; callers keep the low n bits.
    function automatic logic signed [RW-1:0] reduce_n(
        input  logic signed [RW-1:0] v,
        input  int                   n,
        output logic                 ovf
    );
        logic signed [RW-1:0] hi;
        logic signed [RW-1:0] lo;
        logic signed [RW-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (n - 1)) - one;
        lo     = -hi - one;
        ovf    = (v > hi) || (v < lo);
`ifdef ARIMA_SAT_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
`endif
        return v;
    endfunction

endpackage

// File: rtl/arima_serial_core_if.sv
// rtl/arima_serial_core_if.sv - sample-in / forecast-out handshake bundle for arima_serial_core
interface arima_serial_core_if #(
    parameter int N = 32
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/qmult.sv
// rtl/qmult.sv - signed Q-format multiply: full product, arithmetic shift by Q, reduce to N bits
module qmult
    import arima_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] p,
    output logic                ovf
);
    logic signed [2*N-1:0] prod;
    logic signed [RW-1:0]  wide;

    always_comb begin
        prod = (2*N)'(a) * (2*N)'(b);
        wide = RW'(prod >>> Q);
        p    = N'(reduce_n(wide, N, ovf));
    end
endmodule

// File: rtl/arima_serial_core.sv
// rtl/arima_serial_core.sv - serial ARIMA(p,d,q) one-step forecaster sharing one qmult
// ARIMA_SAT_EN (in arima_pkg) switches every N-bit reduction from wrap to saturate.
module arima_serial_core
    import arima_pkg::*;
#(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int P_MAX = 8,
    parameter int Q_MAX = 8,
    parameter int D_MAX = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic [$clog2(P_MAX+1)-1:0]   cfg_p,
    input  logic [$clog2(Q_MAX+1)-1:0]   cfg_q,
    input  logic [$clog2(D_MAX+1)-1:0]   cfg_d,
    input  logic signed [N-1:0]          ar_coef [0:P_MAX-1],
    input  logic signed [N-1:0]          ma_coef [0:Q_MAX-1],
    input  logic signed [N-1:0]          cont,
    input  logic signed [N-1:0]          kalman_beta,
    output logic                         overflow,
    output logic                         busy,
    arima_serial_core_if.slave           s
);
    localparam int PW = $clog2(P_MAX + 1);
    localparam int QW = $clog2(Q_MAX + 1);
    localparam int DW = $clog2(D_MAX + 1);
    localparam int CW = $clog2(P_MAX + Q_MAX + 1);
    localparam int AW = N + CW;
    localparam int PI = (P_MAX > 1) ? $clog2(P_MAX) : 1;
    localparam int QI = (Q_MAX > 1) ? $clog2(Q_MAX) : 1;

    state_t state, next_state;

    logic [PW-1:0]        p_r;
    logic [QW-1:0]        q_r;
    logic [DW-1:0]        d_r;
    logic signed [N-1:0]  x_r;
    logic signed [N-1:0]  level   [0:D_MAX-1];
    logic signed [N-1:0]  ar_hist [0:P_MAX-1];
    logic signed [N-1:0]  ma_hist [0:Q_MAX-1];
    logic signed [N-1:0]  w_hat;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        idx;
    logic signed [N-1:0]  out_r;

    logic signed [N-1:0]  dk [0:D_MAX];
    logic signed [N-1:0]  w_t, e_t, acc_n, integ;
    logic signed [N-1:0]  qa, qb, qp;
    logic signed [RW-1:0] integ_sum;
    logic                 diff_ovf, e_ovf, acc_ovf, integ_ovf, qm_ovf, ov_tmp;
    logic [CW-1:0]        pq_total;
    logic [PI-1:0]        ar_sel;
    logic [QI-1:0]        ma_sel;

    assign pq_total    = CW'(p_r) + CW'(q_r);
    assign ar_sel      = idx[PI-1:0];
    assign ma_sel      = QI'(idx - CW'(p_r));
    assign s.in_ready  = (state == S_IDLE) && !clr;
    assign s.out_valid = (state == S_OUT);
    assign s.out_data  = out_r;
    assign busy        = (state != S_IDLE);

    qmult #(.N(N), .Q(Q)) u_qmult (
        .a   (qa),
        .b   (qb),
        .p   (qp),
        .ovf (qm_ovf)
    );

    // Differencing chain, innovation, accumulator narrowing and integration sum.
    always_comb begin
        diff_ovf = 1'b0;
        ov_tmp   = 1'b0;
        dk[0]    = x_r;
        for (int k = 1; k <= D_MAX; k++) begin
            dk[k] = dk[k-1];
            if (k <= int'(d_r)) begin
                dk[k]    = N'(reduce_n(RW'(dk[k-1]) - RW'(level[k-1]), N, ov_tmp));
                diff_ovf = diff_ovf | ov_tmp;
            end
        end
        w_t       = dk[D_MAX];
        e_t       = N'(reduce_n(RW'(w_t) - RW'(w_hat), N, e_ovf));
        acc_n     = N'(reduce_n(RW'(acc), N, acc_ovf));
        integ_sum = RW'(w_hat);
        for (int k = 0; k < D_MAX; k++) begin
            if (k < int'(d_r)) integ_sum = integ_sum + RW'(level[k]);
        end
        integ = N'(reduce_n(integ_sum, N, integ_ovf));
    end

    always_comb begin
        if (state == S_SCALE) begin
            qa = kalman_beta;
            qb = acc_n;
        end else if (idx < CW'(p_r)) begin
            qa = ar_coef[ar_sel];
            qb = ar_hist[ar_sel];
        end else begin
            qa = ma_coef[ma_sel];
            qb = ma_hist[ma_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (s.in_valid) next_state = S_DIFF;
            S_DIFF:  next_state = (pq_total == '0) ? S_SCALE : S_MAC;
            S_MAC:   if (idx == pq_total - CW'(1)) next_state = S_SCALE;
            S_SCALE: next_state = S_INTEG;
            S_INTEG: next_state = S_OUT;
            S_OUT:   if (s.out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (clr) next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r      <= '0;
            q_r      <= '0;
            d_r      <= '0;
            x_r      <= '0;
            w_hat    <= '0;
            acc      <= '0;
            idx      <= '0;
            out_r    <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < D_MAX; k++) level[k]   <= '0;
            for (int i = 0; i < P_MAX; i++) ar_hist[i] <= '0;
            for (int j = 0; j < Q_MAX; j++) ma_hist[j] <= '0;
        end else if (clr) begin
            w_hat    <= '0;
            acc      <= '0;
            idx      <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < D_MAX; k++) level[k]   <= '0;
            for (int i = 0; i < P_MAX; i++) ar_hist[i] <= '0;
            for (int j = 0; j < Q_MAX; j++) ma_hist[j] <= '0;
        end else begin
            case (state)
                S_IDLE: if (s.in_valid) begin
                    p_r <= (cfg_p > PW'(P_MAX)) ? PW'(P_MAX) : cfg_p;
                    q_r <= (cfg_q > QW'(Q_MAX)) ? QW'(Q_MAX) : cfg_q;
                    d_r <= (cfg_d > DW'(D_MAX)) ? DW'(D_MAX) : cfg_d;
                    x_r <= s.in_data;
                end
                S_DIFF: begin
                    for (int k = 0; k < D_MAX; k++) begin
                        if (k < int'(d_r)) level[k] <= dk[k];
                    end
                    ar_hist[0] <= w_t;
                    for (int i = 1; i < P_MAX; i++) ar_hist[i] <= ar_hist[i-1];
                    ma_hist[0] <= e_t;
                    for (int j = 1; j < Q_MAX; j++) ma_hist[j] <= ma_hist[j-1];
                    acc      <= AW'(cont);
                    idx      <= '0;
                    overflow <= overflow | diff_ovf | e_ovf;
                end
                S_MAC: begin
                    acc      <= acc + AW'(qp);
                    idx      <= idx + CW'(1);
                    overflow <= overflow | qm_ovf;
                end
                S_SCALE: begin
                    w_hat    <= qp;
                    overflow <= overflow | acc_ovf | qm_ovf;
                end
                S_INTEG: begin
                    out_r    <= integ;
                    overflow <= overflow | integ_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arima_serial_core.sv
// tb/tb_arima_serial_core.sv - scoreboard bench for arima_serial_core (honours ARIMA_SAT_EN)
module tb_arima_serial_core;
    import arima_pkg::*;

    localparam int N     = 32;
    localparam int P_MAX = 8;
    localparam int Q_MAX = 8;
    localparam int D_MAX = 2;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                clr   = 1'b0;
    logic [3:0]          cfg_p = '0;
    logic [3:0]          cfg_q = '0;
    logic [1:0]          cfg_d = '0;
    logic signed [N-1:0] ar_coef [0:P_MAX-1];
    logic signed [N-1:0] ma_coef [0:Q_MAX-1];
    logic signed [N-1:0] cont;
    logic signed [N-1:0] kalman_beta;
    logic                overflow;
    logic                busy;

    int     total = 0;
    int     bad   = 0;
    longint exp_q[$];

    longint m_lvl [0:D_MAX-1];
    longint m_ar  [0:P_MAX-1];
    longint m_ma  [0:Q_MAX-1];
    longint m_what;
    int     m_p, m_q, m_d;

    arima_serial_core_if #(.N(N)) bus ();

    arima_serial_core #(.N(N), .Q(15), .P_MAX(P_MAX), .Q_MAX(Q_MAX), .D_MAX(D_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .cfg_p       (cfg_p),
        .cfg_q       (cfg_q),
        .cfg_d       (cfg_d),
        .ar_coef     (ar_coef),
        .ma_coef     (ma_coef),
        .cont        (cont),
        .kalman_beta (kalman_beta),
        .overflow    (overflow),
        .busy        (busy),
        .s           (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 64'(exp_q.size()), 1);
            else                   check("out_data", 64'(bus.out_data), exp_q.pop_front());
        end
    end

    task automatic model_reset();
        for (int k = 0; k < D_MAX; k++) m_lvl[k] = 0;
        for (int i = 0; i < P_MAX; i++) m_ar[i] = 0;
        for (int j = 0; j < Q_MAX; j++) m_ma[j] = 0;
        m_what = 0;
    endtask

    function automatic longint model_step(input longint x);
        longint dk [0:D_MAX];
        longint w, e, acc, xh;
        dk[0] = x;
        for (int k = 1; k <= m_d; k++) dk[k] = dk[k-1] - m_lvl[k-1];
        w = dk[m_d];
        for (int k = 0; k < m_d; k++) m_lvl[k] = dk[k];
        e = w - m_what;
        for (int i = P_MAX - 1; i > 0; i--) m_ar[i] = m_ar[i-1];
        for (int j = Q_MAX - 1; j > 0; j--) m_ma[j] = m_ma[j-1];
        m_ar[0] = w;
        m_ma[0] = e;
        acc = longint'(cont);
        for (int i = 0; i < m_p; i++) acc += (longint'(ar_coef[i]) * m_ar[i]) >>> 15;
        for (int j = 0; j < m_q; j++) acc += (longint'(ma_coef[j]) * m_ma[j]) >>> 15;
        m_what = (longint'(kalman_beta) * acc) >>> 15;
        xh = m_what;
        for (int k = 0; k < m_d; k++) xh += m_lvl[k];
        return xh;
    endfunction

    task automatic send(input logic signed [N-1:0] x);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic set_cfg(input int p, input int q, input int d);
        cfg_p = 4'(p);
        cfg_q = 4'(q);
        cfg_d = 2'(d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic signed [N-1:0] xs;
        for (int i = 0; i < P_MAX; i++) ar_coef[i] = '0;
        for (int j = 0; j < Q_MAX; j++) ma_coef[j] = '0;
        cont          = '0;
        kalman_beta   = ONE_Q;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", 64'(bus.out_data), 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);

        // asynchronous reset in the middle of MAC
        set_cfg(4, 4, 0);
        send(1000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mac_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        model_reset();

        // AR(1), latency
        set_cfg(1, 0, 0);
        ar_coef[0] = 16384;
        cont = 0;
        kalman_beta = 32768;
        exp_q.push_back(16384);
        send(32768);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.out_valid && k < 50);
        check("latency_p1", k, 4);
        drain();

        // d = 1 with constant term
        pulse_clr();
        set_cfg(0, 0, 1);
        ar_coef[0] = 0;
        cont = 8192;
        exp_q.push_back(24576);
        send(16384);
        exp_q.push_back(32768);
        send(24576);
        drain();

        // MA(1)
        pulse_clr();
        set_cfg(0, 1, 0);
        cont = 0;
        ma_coef[0] = 32768;
        exp_q.push_back(16384);
        send(16384);
        exp_q.push_back(-8192);
        send(8192);
        drain();
        check("ovf_clean", overflow, 0);

        // scale overflow
        pulse_clr();
        set_cfg(0, 0, 0);
        ma_coef[0] = 0;
        cont = 32'h7FFF_FFFF;
        kalman_beta = 65536;
`ifdef ARIMA_SAT_EN
        exp_q.push_back(longint'(32'sh7FFF_FFFF));
`else
        exp_q.push_back(-2);
`endif
        send(5);
        drain();
        check("ovf_set", overflow, 1);
        pulse_clr();
        #1;
        check("ovf_cleared", overflow, 0);

        // back-pressure in OUT, then clr
        set_cfg(1, 0, 1);
        ar_coef[0] = 16384;
        cont = 0;
        kalman_beta = 32768;
        bus.out_ready = 1'b0;
        send(32768);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_valid) check("stall_timeout", bus.out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_data", 64'(bus.out_data), 49152);
            check("stall_in_ready", bus.in_ready, 0);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_out_valid", bus.out_valid, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        exp_q.push_back(49152);
        send(32768);
        drain();

        // mixed orders against the model; cfg_d = 3 clamps to D_MAX
        pulse_clr();
        set_cfg(3, 2, 3);
        m_p = 3;
        m_q = 2;
        m_d = 2;
        for (int i = 0; i < 3; i++) ar_coef[i] = $urandom_range(16384, 0) - 8192;
        for (int j = 0; j < 2; j++) ma_coef[j] = $urandom_range(16384, 0) - 8192;
        cont = $urandom_range(2000, 0) - 1000;
        kalman_beta = $urandom_range(36000, 16384);
        for (int t = 0; t < 8; t++) begin
            xs = $urandom_range(40000, 0) - 20000;
            exp_q.push_back(model_step(longint'(xs)));
            send(xs);
        end
        drain();
        check("model_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
